// File: rtl/div_unit_param_pkg.sv
// Shared state encoding and handshake levels for the parametrised divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_unit_param_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'd0,
        DivByZero = 2'd1,
        DivOn     = 2'd2,
        DivEnd    = 2'd3
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_param_step.sv
// One restoring-division iteration: shift {remainder, dividend} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
module div_unit_param_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             ge;

    // Extra top bit makes the borrow of the trial subtraction visible as a sign bit.
    always_comb begin
        shifted = {rem_i, word_i[WIDTH-1]};
        trial   = shifted - {2'b00, divisor_i};
        ge      = ~trial[WIDTH+1];
        rem_o   = ge ? trial[WIDTH:0] : shifted[WIDTH:0];
        word_o  = {word_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit_param.sv
// Multi-cycle restoring divider, signed/unsigned, result {remainder, quotient}.
// Latency: WIDTH+1 edges after start is sampled; divide-by-zero resolves on the following edge.
// Backpressure: result and ready_o held in END while start_i stays high; annul_i aborts ZERO/ON.
module div_unit_param
    import div_unit_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e             state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [WIDTH:0]         rem_r, rem_n, step_rem;
    logic [WIDTH-1:0]       word_r, word_n, step_word;
    logic [WIDTH-1:0]       dvs_r, dvs_n;
    logic                   neg_q_r, neg_q_n;
    logic                   neg_r_r, neg_r_n;
    logic [2*WIDTH-1:0]     result_n;
    logic                   ready_n, div_zero_n;
    logic [WIDTH-1:0]       abs_a, abs_b, q_fix, r_fix;

    div_unit_param_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_r),
        .word_i    (word_r),
        .divisor_i (dvs_r),
        .rem_o     (step_rem),
        .word_o    (step_word)
    );

    // Magnitudes of the operands; abs(most-negative) wraps to itself and is read as unsigned.
    always_comb begin
        abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        q_fix = neg_q_r ? -word_r : word_r;
        r_fix = neg_r_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
    end

    // Next-state and datapath control; every target holds unless a state changes it.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rem_n      = rem_r;
        word_n     = word_r;
        dvs_n      = dvs_r;
        neg_q_n    = neg_q_r;
        neg_r_n    = neg_r_r;
        result_n   = result_o;
        ready_n    = ready_o;
        div_zero_n = div_zero_o;
        case (state)
            DivFree: begin
                ready_n  = DivResultNotReady;
                result_n = '0;
                if (start_i == DivStart && !annul_i) begin
                    word_n  = abs_a;
                    dvs_n   = abs_b;
                    rem_n   = '0;
                    cnt_n   = '0;
                    neg_q_n = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r_n = signed_div_i && opdata1_i[WIDTH-1];
                    state_n = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    state_n = DivFree;
                end else begin
                    state_n    = DivEnd;
                    result_n   = '0;
                    div_zero_n = 1'b1;
                    ready_n    = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_n  = DivFree;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                end else if (cnt != CNT_W'(WIDTH)) begin
                    rem_n  = step_rem;
                    word_n = step_word;
                    cnt_n  = cnt + CNT_W'(1);
                end else begin
                    state_n    = DivEnd;
                    ready_n    = DivResultReady;
                    div_zero_n = 1'b0;
                    result_n   = {r_fix, q_fix};
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_n  = DivFree;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                end
            end
            default: state_n = DivFree;
        endcase
    end

    // State, counter, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DivFree;
            cnt        <= '0;
            rem_r      <= '0;
            word_r     <= '0;
            dvs_r      <= '0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            result_o   <= '0;
            ready_o    <= DivResultNotReady;
            div_zero_o <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rem_r      <= rem_n;
            word_r     <= word_n;
            dvs_r      <= dvs_n;
            neg_q_r    <= neg_q_n;
            neg_r_r    <= neg_r_n;
            result_o   <= result_n;
            ready_o    <= ready_n;
            div_zero_o <= div_zero_n;
        end
    end

    assign busy_o = (state == DivByZero) || (state == DivOn);

endmodule

// File: tb/tb_div_unit_param.sv
// Directed bench for div_unit_param at WIDTH=32 and WIDTH=8.
// Latency: counts edges from the sampling edge of start to ready_o.
// Backpressure: holds start_i in END to check result hold, then drops it.
module tb_div_unit_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=32 instance
    logic        rst32, s32, start32, annul32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        ready32, busy32, dz32;

    // WIDTH=8 instance
    logic        rst8, s8, start8, annul8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        ready8, busy8, dz8;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst32), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(ready32),
        .busy_o(busy32), .div_zero_o(dz32)
    );

    div_unit_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(ready8),
        .busy_o(busy8), .div_zero_o(dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts a divide on the 32-bit unit and waits for ready_o; edges counts
    // the edges after the one that samples start (100 means timeout).
    task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output int edges, output bit busy_ok);
        s32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
        edges = 0; busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready32) break;
            edges++;
            if (!busy32) busy_ok = 1'b0;
            if (scramble) begin
                a32 = $urandom;
                b32 = $urandom;
            end
        end
    endtask

    task automatic drop32();
        start32 = 1'b0;
        @(negedge clk);
    endtask

    int  edges;
    bit  busy_ok;
    bit  saw_ready;
    logic [63:0] held;

    initial begin
        rst32 = 1'b1; s32 = 1'b0; start32 = 1'b0; annul32 = 1'b0; a32 = '0; b32 = '0;
        rst8  = 1'b1; s8  = 1'b0; start8  = 1'b0; annul8  = 1'b0; a8  = '0; b8  = '0;
        repeat (2) @(negedge clk);
        check("rst_result", res32, 64'd0);
        check("rst_ready",  {63'd0, ready32}, 64'd0);
        check("rst_busy",   {63'd0, busy32},  64'd0);
        check("rst_dz",     {63'd0, dz32},    64'd0);
        rst32 = 1'b0; rst8 = 1'b0;
        @(negedge clk);

        // 100 / 7 unsigned
        run32(1'b0, 32'd100, 32'd7, 1'b0, edges, busy_ok);
        check("u100_7_latency", 64'(edges), 64'd33);
        check("u100_7_busy",    {63'd0, busy_ok}, 64'd1);
        check("u100_7_result",  res32, {32'd2, 32'd14});
        check("end_busy_low",   {63'd0, busy32}, 64'd0);
        held = res32;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ready",  {63'd0, ready32}, 64'd1);
            check("hold_result", res32, held);
        end
        drop32();
        check("drop_ready",  {63'd0, ready32}, 64'd0);
        check("drop_result", res32, 64'd0);
        check("drop_busy",   {63'd0, busy32}, 64'd0);

        // Signed -7 / 2
        run32(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, edges, busy_ok);
        check("s_m7_2_result", res32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        drop32();

        // Signed most-negative / -1 wraps
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, edges, busy_ok);
        check("s_ovf_result", res32, {32'd0, 32'h8000_0000});
        check("s_ovf_dz",     {63'd0, dz32}, 64'd0);
        drop32();

        // Divide by zero: busy through ZERO, ready on the edge after the sampling edge
        run32(1'b0, 32'h1234, 32'd0, 1'b0, edges, busy_ok);
        check("dz_latency", 64'(edges), 64'd1);
        check("dz_busy",    {63'd0, busy_ok}, 64'd1);
        check("dz_result",  res32, 64'd0);
        check("dz_flag",    {63'd0, dz32}, 64'd1);
        drop32();
        check("dz_flag_held", {63'd0, dz32}, 64'd1);

        run32(1'b0, 32'd9, 32'd3, 1'b0, edges, busy_ok);
        check("u9_3_result", res32, {32'd0, 32'd3});
        check("u9_3_dz",     {63'd0, dz32}, 64'd0);
        drop32();

        // Annul in the 10th ON cycle of 50 / 5
        s32 = 1'b0; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        annul32 = 1'b1; start32 = 1'b0;
        @(negedge clk);
        check("annul_busy",  {63'd0, busy32},  64'd0);
        check("annul_ready", {63'd0, ready32}, 64'd0);
        annul32 = 1'b0;
        run32(1'b0, 32'd50, 32'd5, 1'b0, edges, busy_ok);
        check("restart_latency", 64'(edges), 64'd33);
        check("restart_result",  res32, {32'd0, 32'd10});
        drop32();

        // Annul then idle: ready_o must stay low
        s32 = 1'b0; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
        repeat (10) @(negedge clk);
        annul32 = 1'b1; start32 = 1'b0;
        @(negedge clk);
        annul32 = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready32) saw_ready = 1'b1;
        end
        check("annul_no_ready", {63'd0, saw_ready}, 64'd0);

        // Operand inputs wiggle during ON; latched values must be used
        run32(1'b0, 32'd1000, 32'd10, 1'b1, edges, busy_ok);
        check("scramble_result", res32, {32'd0, 32'd100});
        drop32();

        // WIDTH=8: 200 / 3
        s8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        edges = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready8) break;
            edges++;
        end
        check("w8_latency", 64'(edges), 64'd9);
        check("w8_result",  {48'd0, res8}, {48'd0, 8'd2, 8'd66});
        start8 = 1'b0;
        @(negedge clk);

        // WIDTH=8: reset mid-operation
        a8 = 8'd250; b8 = 8'd7; start8 = 1'b1;
        repeat (4) @(negedge clk);
        check("w8_busy_mid", {63'd0, busy8}, 64'd1);
        rst8 = 1'b1; start8 = 1'b0;
        @(negedge clk);
        check("w8_rst_outputs", {45'd0, res8, ready8, busy8, dz8}, 64'd0);
        rst8 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
